// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// bus_arb_pkg : shared constants and state encoding for the bus arbiter
// Revision    : 1.0
// ============================================================================
package bus_arb_pkg;
   localparam int NUM_REQ = 8;
   localparam int SEL_W   = 3;
   localparam int HOLD_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      PARK  = 2'd2
   } arb_state_e;
endpackage
`default_nettype wire

// File: rtl/bus_source_arbiter_if.sv
`default_nettype none
// ============================================================================
// bus_source_arbiter_if : request/grant bundle between control logic and arbiter
// Revision              : 1.0
// ============================================================================
interface bus_source_arbiter_if;
   import bus_arb_pkg::*;

   logic [NUM_REQ-1:0] request;
   logic [SEL_W-1:0]   selectValue;
   logic [NUM_REQ-1:0] grant;
   logic               busValid;
   logic [HOLD_W-1:0]  holdCount;

   modport master (
      input  request,
      output selectValue, grant, busValid, holdCount
   );

   modport slave (
      output request,
      input  selectValue, grant, busValid, holdCount
   );
endinterface
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// rr_priority_pick : combinational round-robin winner search (rotate/ffs/unrotate)
// Revision         : 1.0
// ============================================================================
module rr_priority_pick
   import bus_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] request_i,
   input  logic [SEL_W-1:0]   ptr_i,
   output logic [SEL_W-1:0]   winner_o,
   output logic               found_o
);
   logic [2*NUM_REQ-1:0] w_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   logic [SEL_W-1:0]     w_off;

   // Bit 0 of the rotated vector corresponds to the requester at ptr_i.
   assign w_dbl = {request_i, request_i} >> ptr_i;
   assign w_rot = w_dbl[NUM_REQ-1:0];

   always_comb begin
      w_off   = '0;
      found_o = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off   = SEL_W'(i);
            found_o = 1'b1;
         end
      end
   end

   // NUM_REQ is a power of two, so the natural wrap of the sum is the modulo.
   assign winner_o = w_off + ptr_i;
endmodule
`default_nettype wire

// File: rtl/bus_source_arbiter.sv
`default_nettype none
// ============================================================================
// bus_source_arbiter : round-robin owner of the 16-bit register bus (R0..R7)
// Revision           : 1.0
// ============================================================================
module bus_source_arbiter
   import bus_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
)
(
   input  logic               clock,
   input  logic               reset,
   bus_source_arbiter_if.master bus
);
   localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

   arb_state_e         state_q,  state_d;
   logic [NUM_REQ-1:0] grant_q,  grant_d;
   logic [SEL_W-1:0]   sel_q,    sel_d;
   logic [HOLD_W-1:0]  hold_q,   hold_d;
   logic [SEL_W-1:0]   ptr_q,    ptr_d;
   logic               valid_q,  valid_d;

   logic [SEL_W-1:0]   w_winner;
   logic               w_found;

   rr_priority_pick u_pick (
      .request_i (bus.request),
      .ptr_i     (ptr_q),
      .winner_o  (w_winner),
      .found_o   (w_found)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         hold_q  <= '0;
         ptr_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         hold_q  <= hold_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      hold_d  = hold_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      unique case (state_q)
         IDLE: begin
            if (w_found) begin
               state_d = GRANT;
               grant_d = NUM_REQ'(1) << w_winner;
               sel_d   = w_winner;
               hold_d  = HOLD_W'(1);
               valid_d = 1'b1;
            end
         end
         GRANT: begin
            if (bus.request[sel_q] && (hold_q < MAX_HOLD_C)) begin
               hold_d = hold_q + HOLD_W'(1);
            end else begin
               // Pointer moves past the releasing owner; selectValue is kept.
               state_d = PARK;
               grant_d = '0;
               hold_d  = '0;
               valid_d = 1'b0;
               ptr_d   = sel_q + SEL_W'(1);
            end
         end
         PARK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.grant       = grant_q;
   assign bus.selectValue = sel_q;
   assign bus.holdCount   = hold_q;
   assign bus.busValid    = valid_q;
endmodule
`default_nettype wire

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Round-robin arbiter that shares the 16-bit register bus between the eight register-file sources R0..R7.
- Drives the 3-bit selectValue input of mux8by1, so exactly one register's contents appear on outputValue at a time.
- Grants one requester at a time, holds the grant for a bounded burst, then inserts a one-cycle park before re-arbitrating.
- Sits between the processor control logic (which raises per-register read requests) and the bus mux.

Parameters:
- NUM_REQ, 8, number of requesters; fixed to mux8by1 input count.
- SEL_W, 3, select width; equals clog2(NUM_REQ).
- MAX_HOLD, 4, maximum consecutive GRANT cycles per ownership (1..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- request  input  NUM_REQ  per-register bus request; bit i = Ri.
- selectValue  output  SEL_W  select to mux8by1; index of current or last owner.
- grant  output  NUM_REQ  one-hot grant; all zero when no owner.
- busValid  output  1  outputValue is driven by a granted owner this cycle.
- holdCount  output  4  cycles the current owner has held the bus (1..MAX_HOLD); 0 when not in GRANT.

Behaviour:
- All outputs are registered. Nothing is combinational from request to any output.
- Reset (synchronous, one clock edge with reset=1; takes priority over everything):
  - state=IDLE, grant=0, selectValue=0, busValid=0, holdCount=0.
  - Priority pointer rrPtr=0, so R0 has highest priority.
- States: IDLE, GRANT, PARK; 2-bit encoding from the package.
- IDLE:
  - If request==0, stay in IDLE.
  - Otherwise pick winner w = first set bit scanning from rrPtr upward with wrap (rrPtr, rrPtr+1, ..., 7, 0, ..., rrPtr-1).
  - Next edge: state=GRANT, grant=1<<w, selectValue=w, busValid=1, holdCount=1.
  - Latency from request seen in IDLE to grant is 1 clock.
- GRANT:
  - If request[w]==1 and holdCount<MAX_HOLD: stay in GRANT, holdCount+1; grant and selectValue unchanged.
  - If request[w]==0, or holdCount==MAX_HOLD: next edge state=PARK, grant=0, busValid=0, holdCount=0, rrPtr=(w+1) mod NUM_REQ.
  - If both release conditions are true in the same cycle, the result is the same single transition.
- PARK:
  - Exactly 1 cycle, then IDLE. Requests are ignored during PARK.
  - Worst-case request-to-grant latency with other requesters busy is NUM_REQ*(MAX_HOLD+2).
- selectValue holds the last owner index through PARK and IDLE, and changes only on a new grant. This avoids needless mux toggling.
- Requests from non-owners during GRANT have no effect until the next arbitration.
- An owner that re-requests immediately after release loses priority to every other pending requester (pointer moved past it).
- Reset asserted mid-GRANT: the next edge forces the reset values; no PARK cycle is inserted.
- rrPtr wraps from 7 to 0 modulo NUM_REQ; holdCount never exceeds MAX_HOLD.
- Invariants:
  - grant is one-hot or zero.
  - busValid == |grant.
  - When busValid=1, selectValue == index of grant.

Decomposition:
- Package bus_arb_pkg holds:
  - NUM_REQ and SEL_W constants.
  - State enum (IDLE=2'd0, GRANT=2'd1, PARK=2'd2).
  - The holdCount width constant.
- Sub-module rr_priority_pick: purely combinational. Inputs request and rrPtr; outputs winner index and found flag. Implemented as rotate, find-first-set, un-rotate.
- The FSM, hold counter and pointer register live in bus_source_arbiter.

Test Plan:
- Reset check: reset=1 for 2 cycles with request=8'hFF, then reset=0. Expect grant=0, selectValue=0, busValid=0 during reset. First grant is 8'h01 (R0), one clock after reset drops.
- Single requester: request=8'b0010_0000 held for 10 cycles. Expect grant=8'h20, selectValue=5, holdCount 1,2,3,4. Then PARK (busValid=0) for 1 cycle, IDLE for 1 cycle, and a re-grant to R5 (only requester). The mux outputValue reads 5 during every GRANT cycle.
- Early release: R3 requests for 2 cycles only. Expect GRANT with holdCount 1,2, then PARK on the edge after request[3] falls. selectValue stays 3 through PARK and IDLE.
- Round-robin fairness: request=8'b1000_0101 held constant. Expect grant order R0, R2, R7, R0, each lasting 4 cycles with one PARK and one IDLE cycle between.
- Wrap and priority: after R7 is served, R7 and R1 both request. Expect R1 granted first (pointer wrapped to 0).
- Reset mid-grant: assert reset while holdCount=2 for R4. The next edge gives grant=0, busValid=0, selectValue=0, and rrPtr returns to 0: a subsequent request=8'h11 grants R0 first.
